// File: rtl/iter_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iter_sub_pkg
// Brief    : Shared types and constants for the repeated-subtraction engine.
// Revision : 1.0 - initial release
// ============================================================================
package iter_sub_pkg;

    localparam int   DEFAULT_WIDTH = 16;
    localparam logic MODE_DIV      = 1'b0;
    localparam logic MODE_GCD      = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iter_sub_datapath_sub_cmp_unit.sv
`default_nettype none
// ============================================================================
// Module   : sub_cmp_unit
// Brief    : Combinational subtract/compare block shared by DIV and GCD steps.
// Revision : 1.0 - initial release
// ============================================================================
module sub_cmp_unit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_x_minus_y,
    output logic [WIDTH-1:0] o_y_minus_x,
    output logic             o_x_lt_y,
    output logic             o_x_eq_y,
    output logic             o_x_zero,
    output logic             o_y_zero
);

    assign o_x_minus_y = i_x - i_y;
    assign o_y_minus_x = i_y - i_x;
    assign o_x_lt_y    = (i_x < i_y);
    assign o_x_eq_y    = (i_x == i_y);
    assign o_x_zero    = (i_x == '0);
    assign o_y_zero    = (i_y == '0);

endmodule
`default_nettype wire

// File: rtl/iter_sub_datapath.sv
`default_nettype none
// ============================================================================
// Module   : iter_sub_datapath
// Brief    : Multicycle unsigned divide / subtractive GCD engine with
//            start/done handshake. Optional step counter: ITER_SUB_ITER_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module iter_sub_datapath
    import iter_sub_pkg::*;
#(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter logic MODE_DIV = iter_sub_pkg::MODE_DIV,
    parameter logic MODE_GCD = iter_sub_pkg::MODE_GCD
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
`ifdef ITER_SUB_ITER_COUNT_EN
    output logic [WIDTH-1:0] iter_count,
`endif
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] C_ONE = 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, q_q, q_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d, rem_q, rem_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] x_minus_y, y_minus_x;
    logic             x_lt_y, x_eq_y, x_zero, y_zero;
    logic             is_div, is_gcd, run_exit;

    sub_cmp_unit #(.WIDTH(WIDTH)) u_cmp (
        .i_x         (x_q),
        .i_y         (y_q),
        .o_x_minus_y (x_minus_y),
        .o_y_minus_x (y_minus_x),
        .o_x_lt_y    (x_lt_y),
        .o_x_eq_y    (x_eq_y),
        .o_x_zero    (x_zero),
        .o_y_zero    (y_zero)
    );

    assign is_div   = (mode_q == MODE_DIV);
    assign is_gcd   = (mode_q == MODE_GCD);
    assign run_exit = is_div ? (y_zero | x_lt_y) : (x_eq_y | y_zero | x_zero);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            q_q        <= '0;
            mode_q     <= 1'b0;
            result_q   <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            q_q        <= q_d;
            mode_q     <= mode_d;
            result_q   <= result_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (run_exit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        q_d        = q_q;
        mode_d     = mode_q;
        result_d   = result_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        if (state_q == ST_IDLE && start) begin
            x_d    = op_a;
            y_d    = op_b;
            q_d    = '0;
            mode_d = mode;
        end else if (state_q == ST_RUN) begin
            if (is_div) begin
                if (y_zero) begin
                    result_d   = '1;
                    rem_d      = x_q;
                    div_zero_d = 1'b1;
                end else if (x_lt_y) begin
                    result_d   = q_q;
                    rem_d      = x_q;
                    div_zero_d = 1'b0;
                end else begin
                    x_d = x_minus_y;
                    q_d = q_q + C_ONE;
                end
            end else if (is_gcd) begin
                // y==0 is tested before x==0 so GCD(0,0) reports x
                if (x_eq_y || y_zero || x_zero) begin
                    result_d   = (x_eq_y || y_zero) ? x_q : y_q;
                    rem_d      = '0;
                    div_zero_d = 1'b0;
                end else if (!x_lt_y) begin
                    x_d = x_minus_y;
                end else begin
                    y_d = y_minus_x;
                end
            end
        end
    end

`ifdef ITER_SUB_ITER_COUNT_EN
    logic [WIDTH-1:0] steps_q, steps_d, iter_count_q, iter_count_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            steps_q      <= '0;
            iter_count_q <= '0;
        end else begin
            steps_q      <= steps_d;
            iter_count_q <= iter_count_d;
        end
    end

    always_comb begin
        steps_d      = steps_q;
        iter_count_d = iter_count_q;
        if (state_q == ST_IDLE && start) begin
            steps_d = '0;
        end else if (state_q == ST_RUN) begin
            if (run_exit)
                iter_count_d = steps_q;
            else if (steps_q != '1)
                steps_d = steps_q + C_ONE;
        end
    end

    assign iter_count = iter_count_q;
`endif

    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        result   = result_q;
        rem      = rem_q;
        div_zero = div_zero_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_sub_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_sub_datapath
// Brief    : Directed self-checking bench for iter_sub_datapath (16- and 8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_sub_datapath;
    import iter_sub_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0;
    logic [15:0] op_a = '0, op_b = '0;
    logic        busy, done, div_zero;
    logic [15:0] result, rem;
    logic        start8 = 1'b0, mode8 = 1'b0;
    logic [7:0]  op_a8 = '0, op_b8 = '0;
    logic        busy8, done8, div_zero8;
    logic [7:0]  result8, rem8;
`ifdef ITER_SUB_ITER_COUNT_EN
    logic [15:0] iter_count;
    logic [7:0]  iter_count8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iter_sub_datapath #(.WIDTH(16)) dut (
        .CLK(clk), .RST(rst), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .rem(rem),
`ifdef ITER_SUB_ITER_COUNT_EN
        .iter_count(iter_count),
`endif
        .div_zero(div_zero)
    );

    iter_sub_datapath #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .start(start8), .mode(mode8), .op_a(op_a8), .op_b(op_b8),
        .busy(busy8), .done(done8), .result(result8), .rem(rem8),
`ifdef ITER_SUB_ITER_COUNT_EN
        .iter_count(iter_count8),
`endif
        .div_zero(div_zero8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 16-bit operation; edges counts rising edges after the start edge until done.
    task automatic do_op(input string tag, input logic m, input logic [15:0] a, input logic [15:0] b,
                         input int exp_edges, input logic [15:0] exp_res, input logic [15:0] exp_rem,
                         input logic exp_dz, input logic [15:0] exp_iter);
        int edges;
        @(negedge clk);
        start = 1'b1; mode = m; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy"}, busy, 1'b1);
        edges = 0;
        while (!done && edges < 400) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ".latency"}, edges, exp_edges);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".rem"}, rem, exp_rem);
        check({tag, ".div_zero"}, div_zero, exp_dz);
`ifdef ITER_SUB_ITER_COUNT_EN
        check({tag, ".iter_count"}, iter_count, exp_iter);
`else
        if (exp_iter == 16'hDEAD) check({tag, ".unused"}, 0, 1);
`endif
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, {busy, done}, 2'b00);
        check({tag, ".held"}, result, exp_res);
    endtask

    initial begin
        int edges, pulses;

        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.result", result, 16'h0);
        check("reset.rem", rem, 16'h0);
        check("reset.div_zero", div_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        do_op("div7_2",  MODE_DIV, 16'd7,  16'd2, 4, 16'd3,    16'd1, 1'b0, 16'd3);
        do_op("gcd6_2",  MODE_GCD, 16'd6,  16'd2, 3, 16'd2,    16'd0, 1'b0, 16'd2);
        do_op("gcd12_8", MODE_GCD, 16'd12, 16'd8, 3, 16'd4,    16'd0, 1'b0, 16'd2);
        do_op("gcd0_9",  MODE_GCD, 16'd0,  16'd9, 1, 16'd9,    16'd0, 1'b0, 16'd0);
        do_op("div5_0",  MODE_DIV, 16'd5,  16'd0, 1, 16'hFFFF, 16'd5, 1'b1, 16'd0);
        do_op("div4_5",  MODE_DIV, 16'd4,  16'd5, 1, 16'd0,    16'd4, 1'b0, 16'd0);

        // Second start and operand change while running must be ignored.
        @(negedge clk);
        start = 1'b1; mode = MODE_DIV; op_a = 16'd100; op_b = 16'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op_a = 16'd5; op_b = 16'd2;
        @(negedge clk);
        start = 1'b0;
        edges = 4; pulses = 0;
        while (edges < 140) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin
                pulses++;
                if (pulses == 1) check("div100.latency", edges, 101);
            end
        end
        check("div100.pulses", pulses, 1);
        check("div100.result", result, 16'd100);
        check("div100.rem", rem, 16'd0);

        // Reset in the middle of RUN abandons the operation.
        @(negedge clk);
        start = 1'b1; mode = MODE_DIV; op_a = 16'd50; op_b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_run.busy", busy, 1'b0);
        check("rst_run.done", done, 1'b0);
        check("rst_run.result", result, 16'h0);
        check("rst_run.rem", rem, 16'h0);
`ifdef ITER_SUB_ITER_COUNT_EN
        check("rst_run.iter_count", iter_count, 16'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        do_op("div9_3", MODE_DIV, 16'd9, 16'd3, 4, 16'd3, 16'd0, 1'b0, 16'd3);

        // 8-bit instance: largest quotient without wrap.
        @(negedge clk);
        start8 = 1'b1; mode8 = MODE_DIV; op_a8 = 8'd255; op_b8 = 8'd1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0;
        while (!done8 && edges < 400) begin
            @(posedge clk); #1;
            edges++;
        end
        check("w8.latency", edges, 256);
        check("w8.result", result8, 8'hFF);
        check("w8.rem", rem8, 8'h00);
        check("w8.div_zero", div_zero8, 1'b0);
        check("w8.busy", busy8, 1'b1);
`ifdef ITER_SUB_ITER_COUNT_EN
        check("w8.iter_count", iter_count8, 8'hFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
